vga_scan_gen: RTL and testbench
===============================

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 SHALL have parameter H_VIS, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48; these set the horizontal front porch, sync width and back porch in pixels.
REQ-003 SHALL have parameter V_VIS, default 480; V_FP, default 10; V_SYNC, default 2; V_BP, default 33; these set the vertical timing in lines.
REQ-004 SHALL have parameter ANIM_DIV, default 8, meaning frames per animation step.
REQ-005 SHALL have parameter ANIM_LEN, default 8, meaning the number of animation steps before wrap.
REQ-006 SHALL have port vga_clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port pix_ce, input, 1 bit: pixel-advance enable; all state holds when it is low.
REQ-009 SHALL have port DrawX, output, 10 bits: current horizontal count.
REQ-010 SHALL have port DrawY, output, 10 bits: current vertical count.
REQ-011 SHALL have port hs, output, 1 bit: horizontal sync, active-low.
REQ-012 SHALL have port vs, output, 1 bit: vertical sync, active-low.
REQ-013 SHALL have port blank, output, 1 bit: high in the visible region (the display-enable sense).
REQ-014 SHALL have port frame_start, output, 1 bit: single-cycle pulse at count (0,0).
REQ-015 SHALL have port anim_idx, output, 4 bits: animation step index (present only under the macro in REQ-026).

Function
REQ-016 SHALL use H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800) and V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
REQ-017 On a vga_clk edge with pix_ce=1, DrawX SHALL increment; at H_TOT-1 it SHALL wrap to 0 and DrawY SHALL increment in the same cycle.
REQ-018 DrawY at V_TOT-1 SHALL wrap to 0 in the same cycle that DrawX wraps; there is no other wrap point.
REQ-019 With pix_ce=0, all outputs and counters SHALL hold; frame_start SHALL be 0.
REQ-020 hs, vs, blank and frame_start SHALL be registered and decoded from next-state counts, so they align with DrawX/DrawY on the same cycle (zero relative skew).
REQ-021 hs SHALL be 0 exactly when DrawX is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] ([656,751] with defaults).
REQ-022 vs SHALL be 0 exactly when DrawY is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] ([490,491] with defaults).
REQ-023 blank SHALL be 1 exactly when DrawX < H_VIS and DrawY < V_VIS.
REQ-024 frame_start SHALL be 1 only on the cycle that DrawX and DrawY both advance to 0 with pix_ce=1.

Reset
REQ-025 While reset_n=0: DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, anim_idx=0; after release, the first pix_ce cycle SHALL produce (1,0). Reset asserted mid-frame SHALL clear all state immediately, without waiting for a clock.

Configuration
REQ-026 With VGA_ANIM_TICK_EN defined, an internal frame counter SHALL count frame_start pulses; on reaching ANIM_DIV it SHALL clear and anim_idx SHALL increment, wrapping from ANIM_LEN-1 to 0.
REQ-027 Without VGA_ANIM_TICK_EN, the anim_idx port and the frame counter SHALL be absent.

Structure
REQ-028 The default timing constants and the H_TOT/V_TOT derivations SHALL reside in package vga_timing_pkg.
REQ-029 One sub-module, vga_axis_ctr (a wrapping counter with carry-out and a sync-window decode), SHALL be instantiated twice, once for the horizontal axis and once for the vertical axis.

Verification
REQ-030 Reset, then 800 pix_ce cycles -> DrawX returns to 0, DrawY=1; hs is low for exactly 96 cycles, beginning at DrawX=656.
REQ-031 Run one full frame (420000 pix_ce cycles) -> exactly one frame_start; vs low on lines 490-491; blank high on 307200 cycles.
REQ-032 Toggle pix_ce 1/0 alternately -> counts advance only on pix_ce=1 cycles; the frame takes 840000 clocks.
REQ-033 Assert reset_n at DrawX=300, DrawY=200 -> outputs are at reset values before the next edge; counting resumes from (0,0).
REQ-034 With VGA_ANIM_TICK_EN defined, run 64 frames -> anim_idx steps every 8 frames, and reads 0 again after the 64th frame.
REQ-035 At (799,524) with pix_ce=1 -> next state is (0,0) with frame_start=1, blank=1, hs=1, vs=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, the counter width and the axis-total helper
// shared by the scan generator and its axis counters.
package vga_timing_pkg;

  localparam int CNT_W    = 10;
  localparam int H_VIS_D  = 640;
  localparam int H_FP_D   = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D   = 48;
  localparam int V_VIS_D  = 480;
  localparam int V_FP_D   = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D   = 33;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  localparam int H_TOT_D = axis_total(H_VIS_D, H_FP_D, H_SYNC_D, H_BP_D);
  localparam int V_TOT_D = axis_total(V_VIS_D, V_FP_D, V_SYNC_D, V_BP_D);

endpackage

// File: rtl/vga_axis_ctr.sv
// Wrapping axis counter with carry-out; sync window and visible region are decoded
// from the next count so the caller can register them in step with the count.
module vga_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int TOT        = H_TOT_D,
  parameter int VIS        = H_VIS_D,
  parameter int SYNC_START = H_VIS_D + H_FP_D,
  parameter int SYNC_LEN   = H_SYNC_D
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             carry,
  output logic             sync_nxt,
  output logic             vis_nxt
);

  localparam cnt_t LAST_C    = cnt_t'(TOT - 1);
  localparam cnt_t SYNC_LO_C = cnt_t'(SYNC_START);
  localparam cnt_t SYNC_HI_C = cnt_t'(SYNC_START + SYNC_LEN - 1);
  localparam cnt_t VIS_C     = cnt_t'(VIS);

  cnt_t cnt_r;
  cnt_t cnt_nxt_s;
  logic carry_s;

  // Next-count and carry decode.
  always_comb begin
    cnt_nxt_s = cnt_r;
    carry_s   = 1'b0;
    if (inc) begin
      if (cnt_r == LAST_C) begin
        cnt_nxt_s = '0;
        carry_s   = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + cnt_t'(1);
        carry_s   = 1'b0;
      end
    end else begin
      cnt_nxt_s = cnt_r;
      carry_s   = 1'b0;
    end
  end

  // Count register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt      = cnt_r;
  assign carry    = carry_s;
  assign sync_nxt = (cnt_nxt_s >= SYNC_LO_C) && (cnt_nxt_s <= SYNC_HI_C);
  assign vis_nxt  = (cnt_nxt_s < VIS_C);

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: pixel/line counters with registered, zero-skew sync and
// display-enable. Define VGA_ANIM_TICK_EN to add the frame-divided anim_idx output.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS    = H_VIS_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_VIS    = V_VIS_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int ANIM_DIV = 8,
  parameter int ANIM_LEN = 8
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start
`ifdef VGA_ANIM_TICK_EN
  ,
  output logic [3:0] anim_idx
`endif
);

  localparam int H_TOT = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_VIS, V_FP, V_SYNC, V_BP);

  logic h_carry_s, h_sync_s, h_vis_s;
  logic v_carry_s, v_sync_s, v_vis_s;
  logic v_inc_s;
  logic frame_tick_s;
  logic hs_r, vs_r, blank_r, fs_r;

  assign v_inc_s      = pix_ce & h_carry_s;
  assign frame_tick_s = h_carry_s & v_carry_s;

  vga_axis_ctr #(
    .TOT        (H_TOT),
    .VIS        (H_VIS),
    .SYNC_START (H_VIS + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .inc      (pix_ce),
    .cnt      (DrawX),
    .carry    (h_carry_s),
    .sync_nxt (h_sync_s),
    .vis_nxt  (h_vis_s)
  );

  vga_axis_ctr #(
    .TOT        (V_TOT),
    .VIS        (V_VIS),
    .SYNC_START (V_VIS + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .inc      (v_inc_s),
    .cnt      (DrawY),
    .carry    (v_carry_s),
    .sync_nxt (v_sync_s),
    .vis_nxt  (v_vis_s)
  );

  // Sync/enable registers load from next-count decode; frame_start is a one-cycle pulse.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      blank_r <= 1'b0;
      fs_r    <= 1'b0;
    end else if (pix_ce) begin
      hs_r    <= ~h_sync_s;
      vs_r    <= ~v_sync_s;
      blank_r <= h_vis_s & v_vis_s;
      fs_r    <= frame_tick_s;
    end else begin
      fs_r    <= 1'b0;
    end
  end

  assign hs          = hs_r;
  assign vs          = vs_r;
  assign blank       = blank_r;
  assign frame_start = fs_r;

`ifdef VGA_ANIM_TICK_EN
  localparam int FC_W = $clog2(ANIM_DIV + 1);
  localparam logic [FC_W-1:0] DIV_LAST_C = FC_W'(ANIM_DIV - 1);
  localparam logic [3:0]      IDX_LAST_C = 4'(ANIM_LEN - 1);

  logic [FC_W-1:0] frame_cnt_r;
  logic [3:0]      anim_idx_r;

  // Frame divider: steps anim_idx on the same edge that raises frame_start.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_r <= '0;
      anim_idx_r  <= 4'd0;
    end else if (frame_tick_s) begin
      if (frame_cnt_r == DIV_LAST_C) begin
        frame_cnt_r <= '0;
        anim_idx_r  <= (anim_idx_r == IDX_LAST_C) ? 4'd0 : anim_idx_r + 4'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r + FC_W'(1);
      end
    end
  end

  assign anim_idx = anim_idx_r;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a reduced raster; the reference model tracks a
// linear pixel position and derives counts, syncs and pulses from it arithmetically.
`timescale 1ns/1ps
module tb_vga_scan_gen;

  localparam int HV = 12, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int AD = 3,  AL = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_ce  = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       hs, vs, blank, frame_start;
`ifdef VGA_ANIM_TICK_EN
  logic [3:0] anim_idx;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [3:0] anim;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int tests = 0, fails = 0;
  int pos = 0, frames = 0;
  bit moved = 1'b0;
  int fs_seen = 0, hs_low_cnt = 0, vs_low_cnt = 0, blank_cnt = 0;

  always #5 vga_clk = ~vga_clk;

  vga_scan_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ANIM_DIV(AD), .ANIM_LEN(AL)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .hs          (hs),
    .vs          (vs),
    .blank       (blank),
    .frame_start (frame_start)
`ifdef VGA_ANIM_TICK_EN
    ,
    .anim_idx    (anim_idx)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance the linear position, then derive every output from it.
  function automatic exp_t model_step(input bit ce);
    exp_t e;
    int x, y;
    if (ce) begin
      pos   = (pos + 1) % FRAME;
      moved = 1'b1;
      if (pos == 0) frames++;
    end
    x = pos % HT;
    y = pos / HT;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.hs    = !(x >= HV + HF && x < HV + HF + HS);
    e.vs    = !(y >= VV + VF && y < VV + VF + VS);
    e.blank = moved && (x < HV) && (y < VV);
    e.fs    = ce && (pos == 0);
    e.anim  = 4'((frames / AD) % AL);
    return e;
  endfunction

  task automatic drive(input bit ce);
    @(negedge vga_clk);
    #1;
    pix_ce = ce;
    q.push_back(model_step(ce));
  endtask

  task automatic settle();
    @(negedge vga_clk);
    #2;
    pix_ce = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_x"}, 32'(DrawX), 32'd0);
    check({tag, "_y"}, 32'(DrawY), 32'd0);
    check({tag, "_hs"}, 32'(hs), 32'd1);
    check({tag, "_vs"}, 32'(vs), 32'd1);
    check({tag, "_blank"}, 32'(blank), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
`ifdef VGA_ANIM_TICK_EN
    check({tag, "_anim"}, 32'(anim_idx), 32'd0);
`endif
  endtask

  // Monitor: every sampled cycle with a pending expectation is compared and tallied.
  always @(negedge vga_clk) begin
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      check("DrawX", 32'(DrawX), 32'(e_mon.x));
      check("DrawY", 32'(DrawY), 32'(e_mon.y));
      check("hs", 32'(hs), 32'(e_mon.hs));
      check("vs", 32'(vs), 32'(e_mon.vs));
      check("blank", 32'(blank), 32'(e_mon.blank));
      check("frame_start", 32'(frame_start), 32'(e_mon.fs));
`ifdef VGA_ANIM_TICK_EN
      check("anim_idx", 32'(anim_idx), 32'(e_mon.anim));
`endif
      if (frame_start === 1'b1) fs_seen++;
      if (hs === 1'b0) hs_low_cnt++;
      if (vs === 1'b0) vs_low_cnt++;
      if (blank === 1'b1) blank_cnt++;
    end
  end

  initial begin
    int fs0, hs0, vs0, bl0, sx, sy, target, guard;

    #12;
    reset_checks("rst");
    @(negedge vga_clk);
    #2;
    reset_n = 1'b1;

    // One full line from reset: first advance gives (1,0), then wrap to (0,1).
    hs0 = hs_low_cnt;
    for (int i = 0; i < HT; i++) drive(1'b1);
    settle();
    check("line_x", 32'(DrawX), 32'd0);
    check("line_y", 32'(DrawY), 32'd1);
    check("line_hs_low", 32'(hs_low_cnt - hs0), 32'(HS));

    // One full frame at full rate.
    fs0 = fs_seen; vs0 = vs_low_cnt; bl0 = blank_cnt;
    for (int i = 0; i < FRAME; i++) drive(1'b1);
    settle();
    check("frame_fs", 32'(fs_seen - fs0), 32'd1);
    check("frame_vs_low", 32'(vs_low_cnt - vs0), 32'(VS * HT));
    check("frame_blank", 32'(blank_cnt - bl0), 32'(HV * VV));

    // Alternating enable: a frame takes twice as many clocks.
    fs0 = fs_seen; sx = int'(DrawX); sy = int'(DrawY);
    for (int i = 0; i < 2 * FRAME; i++) drive(i[0] == 1'b0);
    settle();
    check("toggle_fs", 32'(fs_seen - fs0), 32'd1);
    check("toggle_x", 32'(DrawX), 32'(sx));
    check("toggle_y", 32'(DrawY), 32'(sy));

    // Randomized enable across enough frames to wrap the animation index.
    target = frames + AD * AL + 2;
    guard = 0;
    while (frames < target && guard < 20000) begin
      drive($urandom_range(0, 3) != 0);
      guard++;
    end
    settle();
    check("rand_frames_reached", 32'(frames >= target), 32'd1);

    // Asynchronous reset mid-frame, then resume from (0,0).
    guard = 0;
    while (pos != 3 * HT + 7 && guard < 4 * FRAME) begin
      drive($urandom_range(0, 1) != 0);
      guard++;
    end
    settle();
    check("mid_x", 32'(DrawX), 32'd7);
    check("mid_y", 32'(DrawY), 32'd3);
    @(posedge vga_clk);
    #2;
    reset_n = 1'b0;
    #1;
    reset_checks("midrst");
    q.delete();
    pos = 0; frames = 0; moved = 1'b0;
    #1;
    reset_n = 1'b1;
    drive(1'b1);
    drive(1'b0);
    drive(1'b1);

    // Last pixel of the frame to (0,0), then hold with enable low.
    guard = 0;
    while (pos != FRAME - 1 && guard < 2 * FRAME) begin
      drive($urandom_range(0, 3) != 0);
      guard++;
    end
    fs0 = fs_seen;
    drive(1'b1);
    drive(1'b0);
    drive(1'b0);
    drive(1'b1);
    settle();
    check("wrap_fs", 32'(fs_seen - fs0), 32'd1);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
